// File: rtl/st_accum_lvl2.sv
// st_accum_lvl2: aligns four level-1 lane results per beat to their largest exponent,
// accumulates a block of beats with exponent tracking and saturation, and presents the partial.
module st_accum_lvl2 #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       prec_mode,
    input  logic [7:0]       acc_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       mant0,
    input  logic [9:0]       mant1,
    input  logic [9:0]       mant2,
    input  logic [9:0]       mant3,
    input  logic [5:0]       exp0,
    input  logic [5:0]       exp1,
    input  logic [5:0]       exp2,
    input  logic [5:0]       exp3,
    input  logic             sign0,
    input  logic             sign1,
    input  logic             sign2,
    input  logic             sign3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-2:0] out_mant,
    output logic [5:0]       out_exp,
    output logic             out_sign,
    output logic             out_ovf
);
    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;
    localparam logic [6:0] SH_LIM   = 7'(ACC_W);
    localparam logic signed [ACC_W:0] SAT_POS = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_NEG = -SAT_POS;

    logic [1:0]              state_q;
    logic [7:0]              cnt_q, len_q;
    logic                    s1_valid_q, s1_first_q;
    logic signed [12:0]      s1_bsum_q;
    logic [5:0]              s1_exp_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [5:0]              acc_exp_q;
    logic                    ovf_q;
    logic                    out_valid_q, out_sign_q;
    logic [ACC_W-2:0]        out_mant_q;
    logic [5:0]              out_exp_q;

    logic [9:0] lane_mant [4];
    logic [5:0] lane_exp  [4];
    logic       lane_sign [4];

    always_comb begin
        lane_mant = '{mant0, mant1, mant2, mant3};
        lane_sign = '{sign0, sign1, sign2, sign3};
        if (prec_mode == 2'b11) lane_exp = '{6'd0, 6'd0, 6'd0, 6'd0};
        else                    lane_exp = '{exp0, exp1, exp2, exp3};
    end

    logic [5:0]         emax, d;
    logic signed [10:0] v, al;
    logic signed [12:0] bsum_d;

    always_comb begin
        emax = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (lane_exp[i] > emax) emax = lane_exp[i];
        bsum_d = '0;
        d      = '0;
        v      = '0;
        al     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            d = emax - lane_exp[i];
            v = lane_sign[i] ? -$signed({1'b0, lane_mant[i]}) : $signed({1'b0, lane_mant[i]});
            if (d >= 6'd11) al = {11{v[10]}};
            else            al = v >>> d;
            bsum_d = bsum_d + {{2{al[10]}}, al};
        end
    end

    logic                    hs, last_beat;
    logic [7:0]              len_in, cur_len;

    assign in_ready  = rst_n && (state_q == ST_ACC);
    assign hs        = in_valid && in_ready;
    assign len_in    = (acc_len == 8'd0) ? 8'd1 : acc_len;
    assign cur_len   = (cnt_q == 8'd0) ? len_in : len_q;
    assign last_beat = hs && (cnt_q == cur_len - 8'd1);

    logic signed [ACC_W-1:0] bs_ext, a_op, b_op, acc_nx;
    logic signed [ACC_W:0]   sum;
    logic [5:0]              exp_nx, sh;
    logic                    sat;
    logic [ACC_W-2:0]        mag_nx;

    // The operand with the smaller exponent is shifted down; shifts past the width give sign fill.
    always_comb begin
        bs_ext = {{(ACC_W-13){s1_bsum_q[12]}}, s1_bsum_q};
        sh     = '0;
        a_op   = acc_q;
        b_op   = bs_ext;
        exp_nx = acc_exp_q;
        if (s1_first_q) begin
            a_op   = '0;
            exp_nx = s1_exp_q;
        end else if (s1_exp_q > acc_exp_q) begin
            sh     = s1_exp_q - acc_exp_q;
            exp_nx = s1_exp_q;
            if ({1'b0, sh} >= SH_LIM) a_op = {ACC_W{acc_q[ACC_W-1]}};
            else                      a_op = acc_q >>> sh;
        end else begin
            sh = acc_exp_q - s1_exp_q;
            if ({1'b0, sh} >= SH_LIM) b_op = {ACC_W{bs_ext[ACC_W-1]}};
            else                      b_op = bs_ext >>> sh;
        end
        sum    = {a_op[ACC_W-1], a_op} + {b_op[ACC_W-1], b_op};
        sat    = 1'b0;
        acc_nx = sum[ACC_W-1:0];
        if (sum > SAT_POS) begin
            acc_nx = SAT_POS[ACC_W-1:0];
            sat    = 1'b1;
        end else if (sum < SAT_NEG) begin
            acc_nx = SAT_NEG[ACC_W-1:0];
            sat    = 1'b1;
        end
        mag_nx = acc_nx[ACC_W-1] ? (ACC_W-1)'(-acc_nx) : acc_nx[ACC_W-2:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            len_q       <= 8'd1;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_bsum_q   <= '0;
            s1_exp_q    <= '0;
            acc_q       <= '0;
            acc_exp_q   <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_sign_q  <= 1'b0;
        end else begin
            s1_valid_q <= hs;
            if (hs) begin
                s1_bsum_q  <= bsum_d;
                s1_exp_q   <= emax;
                s1_first_q <= (cnt_q == 8'd0);
                cnt_q      <= last_beat ? 8'd0 : cnt_q + 8'd1;
                if (cnt_q == 8'd0) len_q <= len_in;
            end
            if (s1_valid_q) begin
                acc_q     <= acc_nx;
                acc_exp_q <= exp_nx;
                if (sat) ovf_q <= 1'b1;
            end
            case (state_q)
                ST_ACC: if (last_beat) state_q <= ST_FLUSH;
                ST_FLUSH: begin
                    // Output registers capture the accumulator including the final beat.
                    state_q     <= ST_OUT;
                    out_valid_q <= 1'b1;
                    out_mant_q  <= mag_nx;
                    out_exp_q   <= exp_nx;
                    out_sign_q  <= acc_nx[ACC_W-1];
                end
                ST_OUT: if (out_ready) begin
                    state_q     <= ST_ACC;
                    out_valid_q <= 1'b0;
                    acc_q       <= '0;
                    acc_exp_q   <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_mant  = out_mant_q;
    assign out_exp   = out_exp_q;
    assign out_sign  = out_sign_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_st_accum_lvl2.sv
// Scoreboard bench for st_accum_lvl2: two instances (24-bit and 14-bit accumulators) share
// stimulus; an arithmetic reference model queues expected results, a monitor pops and compares.
module tb_st_accum_lvl2;
    localparam int WA = 24;
    localparam int WB = 14;

    typedef struct packed {
        logic [3:0][9:0] m;
        logic [3:0][5:0] e;
        logic [3:0]      s;
    } beat_t;

    typedef struct {
        longint mant;
        int     exp;
        bit     sign;
        bit     ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] prec_mode = '0;
    logic [7:0] acc_len = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [9:0] mant0 = '0, mant1 = '0, mant2 = '0, mant3 = '0;
    logic [5:0] exp0 = '0, exp1 = '0, exp2 = '0, exp3 = '0;
    logic sign0 = 1'b0, sign1 = 1'b0, sign2 = 1'b0, sign3 = 1'b0;
    logic in_ready, in_ready_b;
    logic out_valid_a, out_sign_a, out_ovf_a, out_valid_b, out_sign_b, out_ovf_b;
    logic [WA-2:0] out_mant_a;
    logic [WB-2:0] out_mant_b;
    logic [5:0] out_exp_a, out_exp_b;

    int rdy_mode = 0;
    int n_cmp = 0;
    int n_bad = 0;
    res_t qa[$];
    res_t qb[$];
    string  cq_name[$];
    longint cq_act[$];
    longint cq_exp[$];
    logic   hold [2];
    longint pm [2];
    int     pe [2];
    logic   ps [2];
    logic   po [2];

    st_accum_lvl2 dut (
        .clk(clk), .rst_n(rst_n), .prec_mode(prec_mode), .acc_len(acc_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .mant0(mant0), .mant1(mant1), .mant2(mant2), .mant3(mant3),
        .exp0(exp0), .exp1(exp1), .exp2(exp2), .exp3(exp3),
        .sign0(sign0), .sign1(sign1), .sign2(sign2), .sign3(sign3),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_mant(out_mant_a),
        .out_exp(out_exp_a), .out_sign(out_sign_a), .out_ovf(out_ovf_a)
    );

    st_accum_lvl2 #(.ACC_W(WB)) dut14 (
        .clk(clk), .rst_n(rst_n), .prec_mode(prec_mode), .acc_len(acc_len),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .mant0(mant0), .mant1(mant1), .mant2(mant2), .mant3(mant3),
        .exp0(exp0), .exp1(exp1), .exp2(exp2), .exp3(exp3),
        .sign0(sign0), .sign1(sign1), .sign2(sign2), .sign3(sign3),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_mant(out_mant_b),
        .out_exp(out_exp_b), .out_sign(out_sign_b), .out_ovf(out_ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else                    out_ready = 1'b0;
    end

    // Reference model: floor-division alignment on plain integers.
    function automatic longint fdiv(input longint v, input int sh);
        longint p;
        int s;
        s = (sh > 40) ? 40 : sh;
        p = longint'(1) << s;
        if (v >= 0) return v / p;
        return -((-v + p - 1) / p);
    endfunction

    function automatic longint beat_sum(input beat_t b, input logic [1:0] prec, output int emax);
        int e [4];
        longint tot, v;
        emax = 0;
        tot  = 0;
        for (int i = 0; i < 4; i++) begin
            e[i] = (prec == 2'b11) ? 0 : int'(b.e[i]);
            if (e[i] > emax) emax = e[i];
        end
        for (int i = 0; i < 4; i++) begin
            v = longint'(b.m[i]);
            if (b.s[i]) v = -v;
            tot += fdiv(v, emax - e[i]);
        end
        return tot;
    endfunction

    function automatic res_t model_block(input beat_t bs[$], input logic [1:0] prec, input int w);
        res_t r;
        longint lim, acc, bsum;
        int ae, be;
        bit ovf;
        lim = (longint'(1) << (w - 1)) - 1;
        acc = 0;
        ae  = 0;
        ovf = 0;
        for (int k = 0; k < bs.size(); k++) begin
            bsum = beat_sum(bs[k], prec, be);
            if (k == 0) begin
                acc = bsum;
                ae  = be;
            end else if (be > ae) begin
                acc = fdiv(acc, be - ae) + bsum;
                ae  = be;
            end else begin
                acc = acc + fdiv(bsum, ae - be);
            end
            if (acc > lim) begin acc = lim; ovf = 1; end
            else if (acc < -lim) begin acc = -lim; ovf = 1; end
        end
        r.mant = (acc < 0) ? -acc : acc;
        r.exp  = ae;
        r.sign = (acc < 0);
        r.ovf  = ovf;
        return r;
    endfunction

    task automatic cmp(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input longint m, input int e, input logic s, input logic o);
        res_t r;
        string tag;
        tag = (k == 0) ? "a" : "b";
        if (hold[k]) begin
            cmp({"hold_valid_", tag}, longint'(v), 1);
            cmp({"hold_mant_", tag}, m, pm[k]);
            cmp({"hold_exp_", tag}, longint'(e), longint'(pe[k]));
            cmp({"hold_sign_", tag}, longint'(s), longint'(ps[k]));
            cmp({"hold_ovf_", tag}, longint'(o), longint'(po[k]));
        end
        if (v && out_ready) begin
            if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output_%s: got a result, expected none", tag);
            end else begin
                if (k == 0) r = qa.pop_front();
                else        r = qb.pop_front();
                cmp({"out_mant_", tag}, m, r.mant);
                cmp({"out_exp_", tag}, longint'(e), longint'(r.exp));
                cmp({"out_sign_", tag}, longint'(s), longint'(r.sign));
                cmp({"out_ovf_", tag}, longint'(o), longint'(r.ovf));
            end
        end
        hold[k] = v && !out_ready;
        pm[k] = m;
        pe[k] = e;
        ps[k] = s;
        po[k] = o;
    endtask

    always @(negedge clk) begin
        while (cq_name.size() > 0) cmp(cq_name.pop_front(), cq_act.pop_front(), cq_exp.pop_front());
        if (!rst_n) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            mon(0, out_valid_a, longint'(out_mant_a), int'(out_exp_a), out_sign_a, out_ovf_a);
            mon(1, out_valid_b, longint'(out_mant_b), int'(out_exp_b), out_sign_b, out_ovf_b);
        end
    end

    task automatic post(input string nm, input longint act, input longint exp);
        cq_name.push_back(nm);
        cq_act.push_back(act);
        cq_exp.push_back(exp);
    endtask

    task automatic post_zero_outputs(input string pfx);
        post({pfx, "_valid"}, longint'(out_valid_a) + longint'(out_valid_b), 0);
        post({pfx, "_mant"}, longint'(out_mant_a) + longint'(out_mant_b), 0);
        post({pfx, "_exp"}, longint'(out_exp_a) + longint'(out_exp_b), 0);
        post({pfx, "_sign"}, longint'(out_sign_a) + longint'(out_sign_b), 0);
        post({pfx, "_ovf"}, longint'(out_ovf_a) + longint'(out_ovf_b), 0);
    endtask

    task automatic send_beat(input beat_t b);
        bit done;
        done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                mant0 = b.m[0]; mant1 = b.m[1]; mant2 = b.m[2]; mant3 = b.m[3];
                exp0 = b.e[0]; exp1 = b.e[1]; exp2 = b.e[2]; exp3 = b.e[3];
                sign0 = b.s[0]; sign1 = b.s[1]; sign2 = b.s[2]; sign3 = b.s[3];
                in_valid = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) post("in_ready_timeout", 0, 1);
    endtask

    task automatic run_block(input int lenf, input logic [1:0] prec, input beat_t bs[$],
                             input int n_send, input bit idle);
        prec_mode = prec;
        acc_len   = 8'(lenf);
        for (int k = 0; k < n_send; k++) begin
            if (idle && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_beat(bs[k]);
            if (k == 0) acc_len = 8'($urandom_range(0, 255));
            if (k == bs.size() - 1) begin
                qa.push_back(model_block(bs, prec, WA));
                qb.push_back(model_block(bs, prec, WB));
            end
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 1000 && (qa.size() + qb.size()) > 0; t++) @(negedge clk);
        post("drain_pending", longint'(qa.size() + qb.size()), 0);
    endtask

    function automatic beat_t gen_beat(input int erng);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.m[i] = 10'($urandom_range(0, 1023));
            b.e[i] = 6'($urandom_range(0, erng));
            b.s[i] = 1'($urandom_range(0, 1));
        end
        return b;
    endfunction

    initial begin
        beat_t bs[$];
        beat_t b;
        int lenf, len;

        repeat (3) @(negedge clk);
        post("rst_in_ready", longint'(in_ready) + longint'(in_ready_b), 0);
        post_zero_outputs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-beat integer block and its latency.
        bs.delete();
        b = '0; b.m[0] = 10'd5; b.m[1] = 10'd3; b.s[1] = 1'b1;
        bs.push_back(b);
        run_block(1, 2'b11, bs, 1, 0);
        @(negedge clk);
        post("lat_flush_valid", longint'(out_valid_a), 0);
        post("lat_flush_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        post("lat_out_valid", longint'(out_valid_a), 1);
        @(negedge clk);
        post("in_ready_after_out", longint'(in_ready), 1);

        // Realignment of an earlier beat to a larger exponent.
        bs.delete();
        b = '0; b.m = {10'd8, 10'd8, 10'd8, 10'd8}; b.e = {6'd2, 6'd2, 6'd4, 6'd4};
        bs.push_back(b);
        b = '0; b.m[0] = 10'd1; b.e = {6'd6, 6'd6, 6'd6, 6'd6};
        bs.push_back(b);
        run_block(2, 2'b00, bs, 2, 0);

        // Floor of a negative half.
        bs.delete();
        b = '0; b.m[0] = 10'd3; b.s[0] = 1'b1; b.e = {6'd1, 6'd1, 6'd1, 6'd0};
        bs.push_back(b);
        run_block(1, 2'b00, bs, 1, 0);

        // Saturation of the narrow instance, then a clean block.
        bs.delete();
        b = '0; b.m = {10'd1023, 10'd1023, 10'd1023, 10'd1023};
        repeat (3) bs.push_back(b);
        run_block(3, 2'b11, bs, 3, 0);
        bs.delete();
        b = '0; b.m[2] = 10'd7;
        bs.push_back(b);
        run_block(0, 2'b11, bs, 1, 0);

        // Output backpressure with a beat offered during FLUSH/OUT.
        wait_drain();
        rdy_mode = 2;
        bs.delete();
        bs.push_back(gen_beat(15));
        bs.push_back(gen_beat(15));
        run_block(2, 2'b01, bs, 2, 0);
        b = gen_beat(15);
        mant0 = b.m[0]; exp0 = b.e[0]; sign0 = b.s[0];
        in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            post("busy_in_ready", longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!out_valid_a) break;
        end
        post("bp_in_ready_after_out", longint'(in_ready), 1);
        bs.delete();
        bs.push_back(gen_beat(7));
        bs.push_back(gen_beat(7));
        bs.push_back(gen_beat(7));
        run_block(3, 2'b10, bs, 3, 0);

        // Reset after two of four beats discards the block.
        wait_drain();
        bs.delete();
        repeat (4) bs.push_back(gen_beat(15));
        run_block(4, 2'b00, bs, 2, 0);
        rst_n = 1'b0;
        @(negedge clk);
        post("rst_mid_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        post_zero_outputs("rst_mid");
        bs.delete();
        bs.push_back(gen_beat(15));
        run_block(1, 2'b00, bs, 1, 0);

        // Randomized blocks with idle input cycles and random output backpressure.
        wait_drain();
        rdy_mode = 1;
        for (int blk = 0; blk < 40; blk++) begin
            lenf = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 5));
            len  = (lenf == 0) ? 1 : lenf;
            bs.delete();
            for (int k = 0; k < len; k++) bs.push_back(gen_beat((blk % 3 == 0) ? 63 : (blk % 3 == 1) ? 15 : 3));
            run_block(lenf, 2'($urandom_range(0, 3)), bs, len, 1);
        end
        wait_drain();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
